// File: rtl/note_midi_tx.sv
// note_midi_tx: turns the mono note/gate pair into MIDI Note On / Note Off messages on a UART line.
// Latency: inputs are registered once and decided one edge later, so the start bit shows two edges after an input change.
// No backpressure: only the newest input state is sent, and changes made while a message is in flight are coalesced.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (running status; Note Off goes out as Note On with velocity 0).
module note_midi_tx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 31250,
  parameter int CHANNEL  = 0,
  parameter int VELOCITY = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] in_note,
  input  logic       in_gate,
  output logic       midi_tx,
  output logic       busy,
  output logic       msg_sent
);

  // Clock cycles per serial bit; must be at least 2.
  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] DIV_PRE  = CNT_W'(DIV - 2);

  localparam logic [7:0] ST_ON  = 8'h90 | {4'h0, 4'(CHANNEL)};
  localparam logic [7:0] ST_OFF = 8'h80 | {4'h0, 4'(CHANNEL)};
  localparam logic [7:0] VEL_ON = {1'b0, 7'(VELOCITY)};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  // Index of the byte currently on the wire: 0 status, 1 note, 2 velocity.
  logic [1:0]       byte_idx;
  logic [7:0]       shreg;
  logic [7:0]       msg_note;
  logic [7:0]       msg_vel;

  // What the far end believes is playing.
  logic             sent_gate;
  logic [6:0]       sent_note;

  // Input sample registers; all decisions use these, never the raw inputs.
  logic             s_gate;
  logic [6:0]       s_note;

`ifdef MIDI_RUNNING_STATUS_EN
  // 8'h00 is never a status byte, so it stands for "nothing sent yet".
  logic [7:0]       last_status;
`endif

  // Decision terms and the message that would be loaded this cycle.
  logic             want_on;
  logic             want_off;
  logic [7:0]       ld_status;
  logic [6:0]       ld_note;
  logic [7:0]       ld_vel;
  logic [1:0]       ld_first;

  // Register the incoming note/gate once.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_gate <= 1'b0;
      s_note <= '0;
    end else begin
      s_gate <= in_gate;
      s_note <= in_note;
    end
  end

  // Pick the next message from the sampled inputs versus what was last sent.
  always_comb begin
    want_on   = s_gate && !sent_gate;
    want_off  = sent_gate && (!s_gate || (s_note != sent_note));
    ld_status = ST_ON;
    ld_note   = s_note;
    ld_vel    = VEL_ON;
    ld_first  = 2'd0;
    if (!want_on) begin
      // Note Off always refers to the note the far end is holding.
      ld_note = sent_note;
`ifdef MIDI_RUNNING_STATUS_EN
      ld_vel  = 8'h00;
`else
      ld_status = ST_OFF;
      ld_vel    = 8'h40;
`endif
    end
`ifdef MIDI_RUNNING_STATUS_EN
    // Skip the status byte when it repeats the previous one.
    if (ld_status == last_status) begin
      ld_first = 2'd1;
    end
`endif
  end

  // Serial transmitter FSM: idle decision, then start/data/stop per byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      msg_note  <= '0;
      msg_vel   <= '0;
      sent_gate <= 1'b0;
      sent_note <= '0;
      midi_tx   <= 1'b1;
      busy      <= 1'b0;
      msg_sent  <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status <= 8'h00;
`endif
    end else begin
      msg_sent <= 1'b0;
      case (state)
        IDLE: begin
          midi_tx <= 1'b1;
          if (want_on || want_off) begin
            // Latch the whole message now; later input changes wait for the next decision.
            state     <= START;
            div_cnt   <= '0;
            midi_tx   <= 1'b0;
            busy      <= 1'b1;
            byte_idx  <= ld_first;
            msg_note  <= {1'b0, ld_note};
            msg_vel   <= ld_vel;
            shreg     <= (ld_first == 2'd0) ? ld_status : {1'b0, ld_note};
            sent_gate <= want_on;
            if (want_on) begin
              sent_note <= s_note;
            end
`ifdef MIDI_RUNNING_STATUS_EN
            last_status <= ld_status;
`endif
          end
        end

        START: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= DATA;
            midi_tx <= shreg[0];
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        DATA: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              midi_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              midi_tx <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        STOP: begin
          // Pulse lands in the very last cycle of the final stop bit.
          if ((div_cnt == DIV_PRE) && (byte_idx == 2'd2)) begin
            msg_sent <= 1'b1;
          end
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (byte_idx == 2'd2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              // Next byte follows with no idle gap.
              state    <= START;
              midi_tx  <= 1'b0;
              byte_idx <= byte_idx + 2'd1;
              shreg    <= (byte_idx == 2'd0) ? msg_note : msg_vel;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          midi_tx <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
